// File: rtl/alut_age_checker22.sv
// alut_age_checker22 -- ALUT22 age checker.
//   Answers single-cycle in-date queries from the address checker and, on
//   command 2'b10, sweeps all 256 ALUT22 entries invalidating stale ones.
// Ports:
//   pclk22, p_reset22          clock / synchronous active-high reset
//   command                    2'b10 starts a sweep (ignored unless IDLE)
//   check_age22, last_accessed22  query request and timestamp under test
//   curr_time22, best_bfr_age22   current time, maximum allowed age
//   mem_read_data_age22        ALUT22 read data (one cycle after address)
//   age_confirmed22, age_ok22  query response pulse and result
//   mem_addr_age22, mem_write_age22, mem_write_data_age22  ALUT22 access
//   age_check_active22         sweep in progress
//   lst_inv_addr_cmd22, lst_inv_port_cmd22  last invalidated entry
//   inval_count22, sweep_done22  invalidation count, end-of-sweep pulse
module alut_age_checker22 (
  input  logic        pclk22,
  input  logic        p_reset22,
  input  logic [1:0]  command,
  input  logic        check_age22,
  input  logic [31:0] last_accessed22,
  input  logic [31:0] curr_time22,
  input  logic [31:0] best_bfr_age22,
  input  logic [82:0] mem_read_data_age22,
  output logic        age_confirmed22,
  output logic        age_ok22,
  output logic [7:0]  mem_addr_age22,
  output logic        mem_write_age22,
  output logic [82:0] mem_write_data_age22,
  output logic        age_check_active22,
  output logic [47:0] lst_inv_addr_cmd22,
  output logic [1:0]  lst_inv_port_cmd22,
  output logic [8:0]  inval_count22,
  output logic        sweep_done22
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_WR, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_idx;
  logic [81:0] r_data;       // entry captured in EVAL; valid bit not needed
  logic        r_conf, r_ok;
  logic [47:0] r_lst_addr;
  logic [1:0]  r_lst_port;
  logic [8:0]  r_cnt;

  // Modular subtraction handles timer wrap without special cases.
  logic [31:0] w_age_q, w_age_e;
  logic        w_stale, w_last;

  assign w_age_q = curr_time22 - last_accessed22;
  assign w_age_e = curr_time22 - mem_read_data_age22[81:50];
  assign w_stale = mem_read_data_age22[82] && (w_age_e > best_bfr_age22);
  assign w_last  = (r_idx == 8'd255);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (command == 2'b10) w_next = S_RD;
      S_RD:   w_next = S_EVAL;
      S_EVAL: begin
        if (w_stale)     w_next = S_WR;
        else if (w_last) w_next = S_DONE;
        else             w_next = S_RD;
      end
      S_WR:   w_next = w_last ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk22) begin
    if (p_reset22) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_data     <= '0;
      r_conf     <= 1'b0;
      r_ok       <= 1'b0;
      r_lst_addr <= '0;
      r_lst_port <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      // Query path runs regardless of sweep state.
      r_conf  <= check_age22;
      r_ok    <= check_age22 && (w_age_q <= best_bfr_age22);
      case (r_state)
        S_IDLE: if (command == 2'b10) begin
          r_idx <= '0;
          r_cnt <= '0;
        end
        S_EVAL: begin
          r_data <= mem_read_data_age22[81:0];
          if (!w_stale && !w_last) r_idx <= r_idx + 8'd1;
        end
        S_WR: begin
          r_lst_addr <= r_data[47:0];
          r_lst_port <= r_data[49:48];
          r_cnt      <= r_cnt + 9'd1;
          if (!w_last) r_idx <= r_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr_age22       = '0;
    mem_write_age22      = 1'b0;
    mem_write_data_age22 = '0;
    case (r_state)
      S_RD, S_EVAL: mem_addr_age22 = r_idx;
      S_WR: begin
        mem_addr_age22       = r_idx;
        mem_write_age22      = 1'b1;
        mem_write_data_age22 = {1'b0, r_data};  // clear valid only
      end
      default: ;
    endcase
  end

  assign age_confirmed22    = r_conf;
  assign age_ok22           = r_ok;
  assign age_check_active22 = (r_state != S_IDLE);
  assign sweep_done22       = (r_state == S_DONE);
  assign lst_inv_addr_cmd22 = r_lst_addr;
  assign lst_inv_port_cmd22 = r_lst_port;
  assign inval_count22      = r_cnt;

endmodule

// File: tb/tb_alut_age_checker22.sv
module tb_alut_age_checker22;
  logic        pclk22 = 1'b0;
  logic        p_reset22;
  logic [1:0]  command;
  logic        check_age22;
  logic [31:0] last_accessed22, curr_time22, best_bfr_age22;
  logic [82:0] mem_read_data_age22;
  logic        age_confirmed22, age_ok22, mem_write_age22;
  logic [7:0]  mem_addr_age22;
  logic [82:0] mem_write_data_age22;
  logic        age_check_active22, sweep_done22;
  logic [47:0] lst_inv_addr_cmd22;
  logic [1:0]  lst_inv_port_cmd22;
  logic [8:0]  inval_count22;

  always #5 pclk22 = ~pclk22;

  alut_age_checker22 dut (
    .pclk22(pclk22), .p_reset22(p_reset22), .command(command),
    .check_age22(check_age22), .last_accessed22(last_accessed22),
    .curr_time22(curr_time22), .best_bfr_age22(best_bfr_age22),
    .mem_read_data_age22(mem_read_data_age22),
    .age_confirmed22(age_confirmed22), .age_ok22(age_ok22),
    .mem_addr_age22(mem_addr_age22), .mem_write_age22(mem_write_age22),
    .mem_write_data_age22(mem_write_data_age22),
    .age_check_active22(age_check_active22),
    .lst_inv_addr_cmd22(lst_inv_addr_cmd22),
    .lst_inv_port_cmd22(lst_inv_port_cmd22),
    .inval_count22(inval_count22), .sweep_done22(sweep_done22)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit          q_qry[$];
  logic [90:0] q_wr[$];    // {addr, data}

  // Memory model: image written by stimulus, valid-bit clears tracked
  // separately so the DUT write path has a single driver.
  logic [82:0]  img [256];
  logic [255:0] clr;
  logic         clr_rst;

  always @(posedge pclk22) begin
    mem_read_data_age22 <= {img[mem_addr_age22][82] & ~clr[mem_addr_age22],
                            img[mem_addr_age22][81:0]};
    if (clr_rst) clr <= '0;
    else if (mem_write_age22) clr[mem_addr_age22] <= 1'b1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge pclk22) begin
    if (age_confirmed22) begin
      if (q_qry.size() == 0) check("qry_unexpected", age_confirmed22, 0);
      else check("qry_ok", age_ok22, q_qry.pop_front());
    end else check("ok_idle", age_ok22, 0);
    if (mem_write_age22) begin
      if (q_wr.size() == 0) check("wr_unexpected", mem_write_age22, 0);
      else check("wr_data", {mem_addr_age22, mem_write_data_age22}, q_wr.pop_front());
    end
  end

  function automatic logic [82:0] ent(bit v, logic [31:0] t, logic [1:0] p, logic [47:0] a);
    return {v, t, p, a};
  endfunction

  task automatic tick;
    @(posedge pclk22); #1;
  endtask

  task automatic query(input logic [31:0] last, input logic [31:0] cur,
                       input logic [31:0] mx, input bit exp);
    last_accessed22 = last; curr_time22 = cur; best_bfr_age22 = mx;
    check_age22 = 1'b1; q_qry.push_back(exp);
    tick;
    check_age22 = 1'b0;
  endtask

  function automatic logic [154:0] all_outs();
    return {age_confirmed22, age_ok22, mem_addr_age22, mem_write_age22,
            mem_write_data_age22, age_check_active22, lst_inv_addr_cmd22,
            lst_inv_port_cmd22, inval_count22, sweep_done22};
  endfunction

  task automatic run_sweep(input int nstale, input bit inject);
    int cyc = 0;
    bit inj = 0, clr_nxt = 0;
    command = 2'b10; tick; command = 2'b00;
    while (cyc < 2000) begin
      @(negedge pclk22); cyc++;
      if (clr_nxt) begin check_age22 = 1'b0; command = 2'b00; clr_nxt = 0; end
      if (cyc == 1) check("active_run", age_check_active22, 1);
      if (sweep_done22) break;
      if (inject && !inj && mem_write_age22) begin
        last_accessed22 = 32'd950; check_age22 = 1'b1; command = 2'b10;
        q_qry.push_back(1'b1); inj = 1; clr_nxt = 1;
      end
    end
    check("sweep_len", cyc, 513 + nstale);
    if (inject) check("inject_hit", inj, 1);
    @(negedge pclk22);
    check("active_end", age_check_active22, 0);
  endtask

  initial begin
    int cyc;
    bit done_seen;
    p_reset22 = 1'b1; command = 2'b00; check_age22 = 1'b0;
    last_accessed22 = '0; curr_time22 = '0; best_bfr_age22 = '0; clr_rst = 1'b1;
    for (int i = 0; i < 256; i++) img[i] = ent(1'b1, 32'd950, 2'(i % 4), 48'(i));
    repeat (2) tick;
    @(negedge pclk22);
    check("reset_outs", all_outs(), 0);
    p_reset22 = 1'b0; clr_rst = 1'b0;
    tick;

    // Queries: boundary, just-stale, wrap, zero max age, back-to-back
    query(32'd40, 32'd100, 32'd60, 1'b1);
    query(32'd39, 32'd100, 32'd60, 1'b0);
    query(32'hFFFF_FFFB, 32'd5, 32'd10, 1'b1);
    query(32'hFFFF_FFFA, 32'd5, 32'd10, 1'b0);
    query(32'd77, 32'd77, 32'd0, 1'b1);
    query(32'd76, 32'd77, 32'd0, 1'b0);
    tick;
    // Reset swallows a same-cycle query
    check_age22 = 1'b1; p_reset22 = 1'b1; tick;
    check_age22 = 1'b0; p_reset22 = 1'b0; tick; tick;
    check("qry_drain", q_qry.size(), 0);

    // Sweep 1: all fresh, plus an invalid ancient entry
    curr_time22 = 32'd1000; best_bfr_age22 = 32'd100;
    img[20] = ent(1'b0, 32'd0, 2'd0, 48'd20);
    run_sweep(0, 1'b0);
    check("cnt_fresh", inval_count22, 0);

    // Sweep 2: stale at 3 and 255, boundary age at 10, concurrency at WR
    img[3]   = ent(1'b1, 32'd899, 2'd1, 48'h1111_1111_1111);
    img[10]  = ent(1'b1, 32'd900, 2'd3, 48'h2222_2222_2222);
    img[255] = ent(1'b1, 32'd899, 2'd2, 48'h0A0B_0C0D_0E0F);
    q_wr.push_back({8'd3,   1'b0, img[3][81:0]});
    q_wr.push_back({8'd255, 1'b0, img[255][81:0]});
    run_sweep(2, 1'b1);
    check("cnt_stale", inval_count22, 2);
    check("lst_addr", lst_inv_addr_cmd22, 48'h0A0B_0C0D_0E0F);
    check("lst_port", lst_inv_port_cmd22, 2);
    check("clr_map", {clr[255], clr[10], clr[3]}, 3'b101);
    check("wr_drain", q_wr.size(), 0);
    check("qry_drain2", q_qry.size(), 0);

    // Reset mid-sweep at idx 100
    command = 2'b10; tick; command = 2'b00;
    cyc = 0;
    while (cyc < 1000 && mem_addr_age22 != 8'd100) begin
      @(negedge pclk22); cyc++;
    end
    check("reach_idx100", mem_addr_age22, 100);
    p_reset22 = 1'b1;
    @(negedge pclk22);
    check("midreset_outs", all_outs(), 0);
    p_reset22 = 1'b0;
    done_seen = 0;
    repeat (600) begin
      @(negedge pclk22);
      if (sweep_done22 || age_check_active22) done_seen = 1;
    end
    check("no_resume", done_seen, 0);
    check("wr_drain_end", q_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
